// File: rtl/down_timer.sv
// =============================================================================
// down_timer : one-shot / periodic down-counter with IDLE/RUN/PAUSE/DONE FSM.
// Optional DOWN_TIMER_AUTO_RELOAD_EN : reload and keep running on terminal count.
// Revision   : 1.0
// =============================================================================
`default_nettype none

module down_timer #(
  parameter int unsigned MaxCount  = 6,
  parameter int unsigned DataWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [DataWidth-1:0] load_val,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  output logic [DataWidth-1:0] Q,
  output logic                 TC,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DataWidth-1:0] c_max_count = DataWidth'(MaxCount);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DataWidth-1:0] r_q;
  logic [DataWidth-1:0] w_q_nxt;
  logic [DataWidth-1:0] r_reload;
  logic [DataWidth-1:0] w_reload_nxt;
  logic                 w_q_zero;
  logic                 w_tc_raw;

  assign w_q_zero = (r_q == '0);
  assign w_tc_raw = (r_state == ST_RUN) && en && w_q_zero;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_q      <= c_max_count;
      r_reload <= c_max_count;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
    end
  end

  // Priority: stop, then load (only honoured when not busy), then start/pause, then en.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_q_nxt     = r_reload;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            w_state_nxt  = ST_IDLE;
            w_q_nxt      = load_val;
            w_reload_nxt = load_val;
          end else if (start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (en) begin
            if (!w_q_zero) begin
              w_q_nxt = r_q - DataWidth'(1);
            end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
              w_q_nxt = r_reload;
`else
              w_state_nxt = ST_DONE;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are forced low while reset is being applied.
  assign Q    = r_q;
  assign TC   = reset_n & w_tc_raw;
  assign busy = reset_n & ((r_state == ST_RUN) | (r_state == ST_PAUSE));
  assign done = reset_n & (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_down_timer.sv
// =============================================================================
// tb_down_timer : vector table plus hand sequences, checked through a scoreboard.
// Revision      : 1.0
// =============================================================================
`default_nettype none

module tb_down_timer;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] Q;
  logic       TC;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] lv;
    logic       start;
    logic       pause;
    logic       stop;
    logic       cq;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    string      nm;
    logic       cq;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  down_timer #(
    .MaxCount (6),
    .DataWidth(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .Q       (Q),
    .TC      (TC),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(logic rst, logic e, logic ld, logic [3:0] lv, logic st,
                              logic pa, logic sp, logic cq, logic [3:0] q, logic tc,
                              logic bs, logic dn);
    vec_t v;
    v.rst_n = rst; v.en = e; v.load = ld; v.lv = lv; v.start = st; v.pause = pa;
    v.stop = sp; v.cq = cq; v.q = q; v.tc = tc; v.busy = bs; v.done = dn;
    return v;
  endfunction

  task automatic cmp(input string nm, input string fld, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d want %0d", nm, fld, got, want);
    end
  endtask

  // Drive one cycle of inputs mid-cycle, queue its expectation, check before the next edge.
  task automatic step(input string nm, input vec_t v);
    exp_t e;
    @(negedge clk);
    reset_n  = v.rst_n;
    en       = v.en;
    load     = v.load;
    load_val = v.lv;
    start    = v.start;
    pause    = v.pause;
    stop     = v.stop;
    e.nm = nm; e.cq = v.cq; e.q = v.q; e.tc = v.tc; e.busy = v.busy; e.done = v.done;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    if (e.cq) cmp(e.nm, "Q", int'(Q), int'(e.q));
    cmp(e.nm, "TC", int'(TC), int'(e.tc));
    cmp(e.nm, "busy", int'(busy), int'(e.busy));
    cmp(e.nm, "done", int'(done), int'(e.done));
  endtask

  task automatic cyc(input string nm, input logic e, input logic ld, input logic [3:0] lv,
                     input logic st, input logic pa, input logic sp, input logic [3:0] q,
                     input logic tc, input logic bs, input logic dn);
    step(nm, mk(1'b1, e, ld, lv, st, pa, sp, 1'b1, q, tc, bs, dn));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;

    // Reset, then load 3 and run to terminal count.
    vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 1, 4'd6, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd6, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 4'd3, 0, 0, 0, 1, 4'd6, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 0, 0, 1, 4'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd0, 1, 1, 0));
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 1, 0, 0, 1, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 4'd9, 0, 0, 0, 1, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd9, 0, 0, 0));
`else
    vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 4'd9, 0, 0, 0, 1, 4'd3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1, 4'd9, 0, 0, 0));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Pause at Q=3 with en high, hold four cycles, resume and finish.
    cyc("A_load5",  0, 0, 4'd0, 0, 0, 0, 4'd9, 0, 0, 0);
    cyc("A_load5b", 0, 1, 4'd5, 0, 0, 0, 4'd9, 0, 0, 0);
    cyc("A_start",  0, 0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 0);
    cyc("A_tick5",  1, 0, 4'd0, 0, 0, 0, 4'd5, 0, 1, 0);
    cyc("A_tick4",  1, 0, 4'd0, 0, 0, 0, 4'd4, 0, 1, 0);
    cyc("A_pause",  1, 0, 4'd0, 0, 1, 0, 4'd3, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("A_hold%0d", i), 1, (i == 1), 4'd7, 0, 0, 0, 4'd3, 0, 1, 0);
    end
    cyc("A_resume", 1, 0, 4'd0, 1, 0, 0, 4'd3, 0, 1, 0);
    cyc("A_tick3",  1, 0, 4'd0, 0, 0, 0, 4'd3, 0, 1, 0);
    cyc("A_ld_run", 1, 1, 4'd12, 0, 0, 0, 4'd2, 0, 1, 0);
    cyc("A_tick1",  1, 0, 4'd0, 0, 0, 0, 4'd1, 0, 1, 0);
    cyc("A_tc",     1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 0);
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
    cyc("A_stop",   0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 1);
`else
    cyc("A_stop",   0, 0, 4'd0, 0, 0, 1, 4'd5, 0, 1, 0);
`endif
    cyc("A_idle",   0, 0, 4'd0, 0, 1, 0, 4'd5, 0, 0, 0);

    // Stop and load together mid-run: stop wins, Q returns to the reload value.
    cyc("B_load6",  0, 1, 4'd6, 0, 0, 0, 4'd5, 0, 0, 0);
    cyc("B_start",  0, 0, 4'd0, 1, 0, 0, 4'd6, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("B_tick%0d", i), 1, 0, 4'd0, 0, 0, 0, 4'(6 - i), 0, 1, 0);
    end
    cyc("B_stop_ld", 1, 1, 4'd11, 0, 0, 1, 4'd2, 0, 1, 0);
    cyc("B_idle",   0, 0, 4'd0, 0, 0, 0, 4'd6, 0, 0, 0);

    // Reset mid-run at Q=1 with en high; reload must also return to MaxCount.
    cyc("C_load4",  0, 1, 4'd4, 0, 0, 0, 4'd6, 0, 0, 0);
    cyc("C_start",  0, 0, 4'd0, 1, 0, 0, 4'd4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("C_tick%0d", i), 1, 0, 4'd0, 0, 0, 0, 4'(4 - i), 0, 1, 0);
    end
    step("C_rst_run",  mk(0, 1, 0, 4'd0, 0, 0, 0, 1, 4'd1, 0, 0, 0));
    step("C_post_rst", mk(1, 1, 0, 4'd0, 0, 0, 0, 1, 4'd6, 0, 0, 0));
    cyc("C_start2", 0, 0, 4'd0, 1, 0, 0, 4'd6, 0, 0, 0);
    cyc("C_stop",   0, 0, 4'd0, 0, 0, 1, 4'd6, 0, 1, 0);
    cyc("C_idle",   0, 0, 4'd0, 0, 0, 0, 4'd6, 0, 0, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Periodic mode: load 2 gives TC every third tick and busy never drops.
    cyc("D_load2",  0, 1, 4'd2, 0, 0, 0, 4'd6, 0, 0, 0);
    cyc("D_start",  0, 0, 4'd0, 1, 0, 0, 4'd2, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] q;
      q = 4'(2 - (i % 3));
      cyc($sformatf("D_tick%0d", i), 1, 0, 4'd0, 0, 0, 0, q, (q == 4'd0), 1, 0);
    end
    cyc("D_stop",   0, 0, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0);
    cyc("D_idle",   0, 0, 4'd0, 0, 0, 0, 4'd2, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
